// File: rtl/cmp_seq_nbit_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] RES_LT = 2'b00;
    localparam logic [1:0] RES_EQ = 2'b01;
    localparam logic [1:0] RES_GT = 2'b10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cmp_seq_nbit_if.sv
// Request/result bundle between a compare client and cmp_seq_nbit.
interface cmp_seq_nbit_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
);
    localparam int SW = clog2(WIDTH / DIGIT) + 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             agtb;
    logic             aeqb;
    logic             altb;
    logic [SW-1:0]    slices_used;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, agtb, aeqb, altb, slices_used
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, agtb, aeqb, altb, slices_used
    );
endinterface

// File: rtl/cmp_seq_nbit_slice.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module cmp_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] sa,
    input  logic [DIGIT-1:0] sb,
    output logic             gt,
    output logic             lt
);
    assign gt = (sa > sb);
    assign lt = (sa < sb);
endmodule

// File: rtl/cmp_seq_nbit.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle, with
// optional early exit at the first differing slice.
module cmp_seq_nbit
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DIGIT      = 1,
    parameter bit EARLY_EXIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    cmp_seq_nbit_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int SW = clog2(N) + 1;

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("cmp_seq_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, a_sh, b_sh;
    logic [SW-1:0]    idx;
    logic             decided;
    logic [1:0]       res_r, res_now;
    logic [DIGIT-1:0] sa, sb;
    logic             s_gt, s_lt;
    logic             accept, last;
    logic             agtb_r, aeqb_r, altb_r;
    logic [SW-1:0]    su_r;

    // Slice idx sits at the bottom after shifting out the lower (N-idx) slices.
    assign a_sh = a_r >> ((N - int'(idx)) * DIGIT);
    assign b_sh = b_r >> ((N - int'(idx)) * DIGIT);
    assign sa   = a_sh[DIGIT-1:0];
    assign sb   = b_sh[DIGIT-1:0];

    cmp_slice #(.DIGIT(DIGIT)) u_slice (
        .sa (sa),
        .sb (sb),
        .gt (s_gt),
        .lt (s_lt)
    );

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (idx == SW'(N));

    // A decided result is sticky; later differing slices never override it.
    always_comb begin
        res_now = RES_EQ;
        if (decided)   res_now = res_r;
        else if (s_gt) res_now = RES_GT;
        else if (s_lt) res_now = RES_LT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = SCAN;
            SCAN: begin
                if ((EARLY_EXIT && (decided || s_gt || s_lt)) || last)
                    state_nx = DONE;
            end
            DONE: state_nx = bus.start ? SCAN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            res_r   <= RES_EQ;
            agtb_r  <= 1'b0;
            aeqb_r  <= 1'b0;
            altb_r  <= 1'b0;
            su_r    <= '0;
        end else if (accept) begin
            // Flipping the MSB maps two's complement onto offset binary.
            a_r     <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
            b_r     <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
            idx     <= SW'(1);
            decided <= 1'b0;
            res_r   <= RES_EQ;
        end else if (state == SCAN) begin
            if (!decided && (s_gt || s_lt)) begin
                decided <= 1'b1;
                res_r   <= s_gt ? RES_GT : RES_LT;
            end
            if (state_nx == DONE) begin
                agtb_r <= (res_now == RES_GT);
                aeqb_r <= (res_now == RES_EQ);
                altb_r <= (res_now == RES_LT);
                su_r   <= idx;
            end else begin
                idx <= idx + SW'(1);
            end
        end
    end

    assign bus.busy        = (state == SCAN);
    assign bus.done        = (state == DONE);
    assign bus.agtb        = agtb_r;
    assign bus.aeqb        = aeqb_r;
    assign bus.altb        = altb_r;
    assign bus.slices_used = su_r;

endmodule

// File: tb/tb_cmp_seq_nbit.sv
// Directed and exhaustive checks of cmp_seq_nbit across four configurations.
module tb_cmp_seq_nbit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    cmp_seq_nbit_if #(.WIDTH(4), .DIGIT(1)) if4 ();
    cmp_seq_nbit_if #(.WIDTH(4), .DIGIT(4)) if1 ();
    cmp_seq_nbit_if #(.WIDTH(8), .DIGIT(2)) if8e ();
    cmp_seq_nbit_if #(.WIDTH(8), .DIGIT(2)) if8f ();

    cmp_seq_nbit #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(1)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    cmp_seq_nbit #(.WIDTH(4), .DIGIT(4), .EARLY_EXIT(1)) u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    cmp_seq_nbit #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u8e (.clk(clk), .rst_n(rst_n), .bus(if8e));
    cmp_seq_nbit #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u8f (.clk(clk), .rst_n(rst_n), .bus(if8f));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int msb(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) if (x[i]) return i;
        return -1;
    endfunction

    function automatic logic [2:0] rel(input int av, input int bv);
        if (av > bv)  return 3'b100;
        if (av == bv) return 3'b010;
        return 3'b001;
    endfunction

    // Launches a compare on the 4-bit DUTs and scrambles the operand
    // inputs after the accepting edge; returns done latency and busy cycles.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        output int lat4, output int lat1, output int busy4);
        lat4 = 0; lat1 = 0; busy4 = 0;
        if4.a = a; if4.b = b; if4.signed_mode = sm; if4.start = 1'b1;
        if1.a = a; if1.b = b; if1.signed_mode = sm; if1.start = 1'b1;
        for (int c = 1; c <= 20 && (lat4 == 0 || lat1 == 0); c++) begin
            @(posedge clk); #1;
            if4.start = 1'b0; if1.start = 1'b0;
            if4.a = 4'($urandom); if4.b = 4'($urandom); if4.signed_mode = 1'($urandom);
            if1.a = 4'($urandom); if1.b = 4'($urandom); if1.signed_mode = 1'($urandom);
            if (if4.busy) busy4++;
            if (if4.done && lat4 == 0) lat4 = c;
            if (if1.done && lat1 == 0) lat1 = c;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output int late, output int latf);
        late = 0; latf = 0;
        if8e.a = a; if8e.b = b; if8e.signed_mode = sm; if8e.start = 1'b1;
        if8f.a = a; if8f.b = b; if8f.signed_mode = sm; if8f.start = 1'b1;
        for (int c = 1; c <= 20 && (late == 0 || latf == 0); c++) begin
            @(posedge clk); #1;
            if8e.start = 1'b0; if8f.start = 1'b0;
            if8e.a = 8'($urandom); if8f.b = 8'($urandom);
            if (if8e.done && late == 0) late = c;
            if (if8f.done && latf == 0) latf = c;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if4.start = 0; if4.a = 0; if4.b = 0; if4.signed_mode = 0;
        if1.start = 0; if1.a = 0; if1.b = 0; if1.signed_mode = 0;
        if8e.start = 0; if8e.a = 0; if8e.b = 0; if8e.signed_mode = 0;
        if8f.start = 0; if8f.a = 0; if8f.b = 0; if8f.signed_mode = 0;
        #3;
        tests++;
        if ({if4.busy, if4.done, if4.agtb, if4.aeqb, if4.altb, if4.slices_used} !== 8'h00) begin
            fails++;
            $display("FAIL reset4 got=%b want=0", {if4.busy, if4.done, if4.agtb, if4.aeqb, if4.altb, if4.slices_used});
        end
        tests++;
        if ({if8f.busy, if8f.done, if8f.agtb, if8f.aeqb, if8f.altb, if8f.slices_used} !== 8'h00) begin
            fails++;
            $display("FAIL reset8 got=%b want=0", {if8f.busy, if8f.done, if8f.agtb, if8f.aeqb, if8f.altb, if8f.slices_used});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int l4, l1, bz;
        run4(4'd9, 4'd3, 1'b0, l4, l1, bz);
        tests++;
        if (l4 !== 2 || {if4.agtb, if4.aeqb, if4.altb} !== 3'b100 || if4.slices_used !== 3'd1) begin
            fails++;
            $display("FAIL basic_9v3 lat=%0d res=%b su=%0d want lat=2 res=100 su=1",
                     l4, {if4.agtb, if4.aeqb, if4.altb}, if4.slices_used);
        end
        tests++;
        if (l1 !== 2 || {if1.agtb, if1.aeqb, if1.altb} !== 3'b100 || if1.slices_used !== 1'd1) begin
            fails++;
            $display("FAIL n1_9v3 lat=%0d res=%b want lat=2 res=100", l1, {if1.agtb, if1.aeqb, if1.altb});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int l4, l1, bz;
        run4(4'd5, 4'd5, 1'b0, l4, l1, bz);
        tests++;
        if (l4 !== 5 || {if4.agtb, if4.aeqb, if4.altb} !== 3'b010 || if4.slices_used !== 3'd4 || bz !== 4) begin
            fails++;
            $display("FAIL eq_5v5 lat=%0d res=%b su=%0d busy=%0d want 5 010 4 4",
                     l4, {if4.agtb, if4.aeqb, if4.altb}, if4.slices_used, bz);
        end
        // Second compare is requested in the DONE cycle of the first.
        run4(4'd5, 4'd6, 1'b0, l4, l1, bz);
        tests++;
        if (l4 !== 4 || {if4.agtb, if4.aeqb, if4.altb} !== 3'b001 || if4.slices_used !== 3'd3 || bz !== 3) begin
            fails++;
            $display("FAIL b2b_5v6 lat=%0d res=%b su=%0d busy=%0d want 4 001 3 3",
                     l4, {if4.agtb, if4.aeqb, if4.altb}, if4.slices_used, bz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        int l4, l1, bz;
        logic [3:0] va [4] = '{4'hF, 4'hF, 4'h8, 4'hF};
        logic [3:0] vb [4] = '{4'h1, 4'h1, 4'h7, 4'h0};
        logic       vs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] vr [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
        for (int i = 0; i < 4; i++) begin
            run4(va[i], vb[i], vs[i], l4, l1, bz);
            tests++;
            if (l4 !== 2 || {if4.agtb, if4.aeqb, if4.altb} !== vr[i] || if4.slices_used !== 3'd1) begin
                fails++;
                $display("FAIL signed_%0d lat=%0d res=%b su=%0d want 2 %b 1",
                         i, l4, {if4.agtb, if4.aeqb, if4.altb}, if4.slices_used, vr[i]);
            end
            @(posedge clk); #1;
        end
        // All-ones vs all-zeros flips between modes.
        run4(4'hF, 4'h0, 1'b1, l4, l1, bz);
        tests++;
        if ({if4.agtb, if4.aeqb, if4.altb} !== 3'b001) begin
            fails++;
            $display("FAIL ones_zeros_signed res=%b want 001", {if4.agtb, if4.aeqb, if4.altb});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_in_scan();
        int lat, bz;
        lat = 0; bz = 0;
        if4.a = 4'd5; if4.b = 4'd5; if4.signed_mode = 1'b0; if4.start = 1'b1;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if4.start = (c <= 2);
            if4.a = 4'd9; if4.b = 4'd3;
            if (if4.busy) bz++;
            if (if4.done) lat = c;
        end
        tests++;
        if (lat !== 5 || bz !== 4 || {if4.agtb, if4.aeqb, if4.altb} !== 3'b010) begin
            fails++;
            $display("FAIL start_in_scan lat=%0d busy=%0d res=%b want 5 4 010",
                     lat, bz, {if4.agtb, if4.aeqb, if4.altb});
        end
        @(posedge clk); #1;
        tests++;
        if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
            fails++;
            $display("FAIL start_in_scan_idle busy=%b done=%b want 0 0", if4.busy, if4.done);
        end
    endtask

    task automatic test_reset_midscan();
        int l4, l1, bz, dn;
        if4.a = 4'd5; if4.b = 4'd5; if4.signed_mode = 1'b0; if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({if4.busy, if4.done, if4.agtb, if4.aeqb, if4.altb, if4.slices_used} !== 8'h00) begin
            fails++;
            $display("FAIL reset_midscan got=%b want=0", {if4.busy, if4.done, if4.agtb, if4.aeqb, if4.altb, if4.slices_used});
        end
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) rst_n = 1'b1;
            if (if4.done) dn++;
        end
        tests++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL reset_no_done done_cycles=%0d want 0", dn);
        end
        run4(4'd9, 4'd3, 1'b0, l4, l1, bz);
        tests++;
        if (l4 !== 2 || {if4.agtb, if4.aeqb, if4.altb} !== 3'b100 || if4.slices_used !== 3'd1) begin
            fails++;
            $display("FAIL post_reset lat=%0d res=%b su=%0d want 2 100 1",
                     l4, {if4.agtb, if4.aeqb, if4.altb}, if4.slices_used);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive4();
        int l4, l1, bz, av, bv, k;
        logic [3:0] a, b;
        logic [2:0] er;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    a = 4'(i); b = 4'(j);
                    av = s ? int'($signed(a)) : i;
                    bv = s ? int'($signed(b)) : j;
                    er = rel(av, bv);
                    k  = (a == b) ? 4 : (3 - msb({4'h0, a ^ b})) + 1;
                    run4(a, b, 1'(s), l4, l1, bz);
                    tests++;
                    if (l4 !== k + 1 || bz !== k || if4.slices_used !== 3'(k) ||
                        {if4.agtb, if4.aeqb, if4.altb} !== er) begin
                        fails++;
                        $display("FAIL exh4 a=%0d b=%0d sm=%0d lat=%0d/%0d busy=%0d su=%0d res=%b/%b",
                                 i, j, s, l4, k + 1, bz, if4.slices_used, {if4.agtb, if4.aeqb, if4.altb}, er);
                    end
                    tests++;
                    if (l1 !== 2 || if1.slices_used !== 1'd1 || {if1.agtb, if1.aeqb, if1.altb} !== er) begin
                        fails++;
                        $display("FAIL exh_n1 a=%0d b=%0d sm=%0d lat=%0d/2 res=%b/%b",
                                 i, j, s, l1, {if1.agtb, if1.aeqb, if1.altb}, er);
                    end
                end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep8();
        int le, lf, av, bv, k;
        logic [7:0] a, b;
        logic [2:0] er;
        for (int n = 0; n < 160; n++) begin
            case (n)
                0: begin a = 8'hFF; b = 8'h00; end
                1: begin a = 8'h80; b = 8'h7F; end
                2: begin a = 8'h3C; b = 8'h3C; end
                default: begin a = 8'($urandom); b = (n % 4 == 0) ? a ^ 8'(1 << (n % 8)) : 8'($urandom); end
            endcase
            for (int s = 0; s < 2; s++) begin
                av = s ? int'($signed(a)) : int'(a);
                bv = s ? int'($signed(b)) : int'(b);
                er = rel(av, bv);
                k  = (a == b) ? 4 : (7 - msb(a ^ b)) / 2 + 1;
                run8(a, b, 1'(s), le, lf);
                tests++;
                if (le !== k + 1 || if8e.slices_used !== 3'(k) || {if8e.agtb, if8e.aeqb, if8e.altb} !== er) begin
                    fails++;
                    $display("FAIL sweep8_early a=%h b=%h sm=%0d lat=%0d/%0d su=%0d res=%b/%b",
                             a, b, s, le, k + 1, if8e.slices_used, {if8e.agtb, if8e.aeqb, if8e.altb}, er);
                end
                tests++;
                if (lf !== 5 || if8f.slices_used !== 3'd4 || {if8f.agtb, if8f.aeqb, if8f.altb} !== er) begin
                    fails++;
                    $display("FAIL sweep8_fixed a=%h b=%h sm=%0d lat=%0d/5 su=%0d res=%b/%b",
                             a, b, s, lf, if8f.slices_used, {if8f.agtb, if8f.aeqb, if8f.altb}, er);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_signed();
        test_start_in_scan();
        test_reset_midscan();
        test_exhaustive4();
        test_sweep8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cmp_seq_nbit.md
Name: cmp_seq_nbit

Overview:
Parametrised sequential magnitude comparator, successor to the fixed 4-bit greater-than block.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, under a start/done handshake.
- Supports unsigned and two's-complement modes.
- Reports all three relations (gt/eq/lt) and stops early when the result is known.
- Sits beside the datapath as a shared, low-area compare resource.

Parameters:
WIDTH, 4, operand width in bits; WIDTH >= 2.
DIGIT, 1, bits compared per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise).
EARLY_EXIT, 1, 1 = finish at the first differing slice; 0 = always scan all slices (fixed latency).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when the block accepts (IDLE or DONE)
a  in  WIDTH  operand A, captured on the accepted start
b  in  WIDTH  operand B, captured on the accepted start
signed_mode  in  1  1 = two's complement, 0 = unsigned; captured with the operands
busy  out  1  high while a compare is in progress (SCAN state)
done  out  1  one-cycle pulse; result valid in that cycle
agtb  out  1  A > B
aeqb  out  1  A == B
altb  out  1  A < B
slices_used  out  clog2(WIDTH/DIGIT)+1  slices examined for the last result

Behaviour:
- Reset values: state IDLE; busy=0, done=0, agtb=0, aeqb=0, altb=0, slices_used=0. Operand registers are cleared to 0.
- Reset is asynchronous and takes effect immediately in any state. A compare in flight is discarded and no done is produced.
- States:
  - IDLE: wait for start.
  - SCAN: examine one slice per cycle.
  - DONE: pulse done for one cycle.
- Let N = WIDTH/DIGIT. Slice k (k=1..N) is bits [WIDTH-1-(k-1)*DIGIT -: DIGIT].
- Accept: when start=1 in IDLE or DONE, on that edge:
  - Capture a, b and signed_mode.
  - If signed_mode=1, invert the MSB of both captured operands (offset-binary map), so the unsigned slice compare gives the signed order.
  - Clear the slice index to 1 and the decided flag; go to SCAN.
- SCAN cycle k:
  - Compare slice k of A against slice k of B, unsigned.
  - On the first difference: record gt/lt and set decided.
  - Later differences never overwrite a decided result.
  - EARLY_EXIT=1: go to DONE when a difference is found or k==N.
  - EARLY_EXIT=0: go to DONE only after k==N.
- DONE:
  - done=1 for exactly one cycle.
  - Exactly one of agtb/aeqb/altb is 1. aeqb=1 iff no slice differed.
  - slices_used = number of slices examined (1..N).
  - Next state is IDLE, or SCAN if start=1 in this cycle (back-to-back accept).
- Latency, counted from the accepting edge to the cycle in which done=1: k+1 cycles, where k is the deciding slice index (N if equal). With EARLY_EXIT=0 the latency is always N+1.
- Result outputs: registered, updated only on entry to DONE. They hold their value through IDLE and the next SCAN until the next DONE.
- busy=1 exactly in SCAN cycles.
- start in SCAN is ignored. Operand changes on a/b/signed_mode after the accepting edge have no effect.
- Boundaries:
  - N=1 (DIGIT=WIDTH): latency is always 2.
  - Most negative vs most positive in signed mode resolves at slice 1.
  - All-ones vs all-zeros resolves in unsigned and signed mode with opposite results.

Decomposition:
- Package cmp_pkg:
  - State enum (IDLE, SCAN, DONE).
  - Result encoding constants (RES_LT=2'b00, RES_EQ=2'b01, RES_GT=2'b10).
  - clog2 helper function.
- One sub-module, cmp_slice: combinational DIGIT-bit unsigned compare producing gt and lt. Instantiated once on the muxed current slice.

Test Plan:
1. WIDTH=4, DIGIT=1, EARLY_EXIT=1, unsigned, a=9, b=3 -> agtb=1, slices_used=1, done 2 cycles after the accepting edge.
2. Same config, a=5, b=5 -> aeqb=1, slices_used=4, done at cycle 5. Then a=5, b=6 back-to-back (start held in the DONE cycle) -> altb=1, slices_used=3, no idle cycle between compares.
3. Signed mode, a=4'b1111 (-1), b=4'b0001 -> altb=1 at slice 1. Unsigned mode, same values -> agtb=1.
4. Assert start again during SCAN with different operands -> ignored; the result matches the first operands and busy does not extend.
5. Drop rst_n during SCAN cycle 2 -> all outputs 0 immediately, no done pulse, a fresh start afterwards completes normally.
6. Exhaustive 256 pairs × both modes for WIDTH=4/DIGIT=1, plus random sweeps for WIDTH=8/DIGIT=2 with EARLY_EXIT=0 (latency always 5) and EARLY_EXIT=1. Check against the behavioural model: one-hot result, latency formula, slices_used.
